// File: rtl/ext_mem_arbiter_pkg.sv
// Shared types and constants for the external memory arbiter.
// State encodings, region boundary and master indices.
package gb_mem_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_FWAIT  = 3'd2;
  localparam logic [2:0] ST_BCAP   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ACCESS = ST_ACCESS,
    S_FWAIT  = ST_FWAIT,
    S_BCAP   = ST_BCAP,
    S_DONE   = ST_DONE
  } state_e;

  localparam logic [15:0] FLASH_TOP_DEFAULT = 16'h0140;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

endpackage

// File: rtl/ext_mem_arbiter_if.sv
// One requester port of the external memory arbiter.
// Master drives the request; slave answers gnt/done/rdata.
interface ext_mem_arbiter_if;

  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        gnt;
  logic        done;
  logic [7:0]  rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, done, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, done, rdata
  );

endinterface

// File: rtl/ext_mem_arbiter_arb_prio_starve.sv
// Fixed m1 priority with a starvation escape for m0.
// Winner is combinational; the loss counter is registered.
module arb_prio_starve
  import gb_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic decide,
  input  logic req0,
  input  logic req1,
  output logic winner,
  output logic valid
);

  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q, cnt_d;

  // m1 wins conflicts unless m0 has lost LIM times in a row
  always_comb begin
    valid  = req0 | req1;
    winner = MST_CPU;
    if (req1 && !(req0 && cnt_q == LIM))
      winner = MST_DMA;
  end

  // Count m0 losses, saturating; clear when m0 is served
  always_comb begin
    cnt_d = cnt_q;
    if (decide && valid) begin
      if (winner == MST_CPU)
        cnt_d = '0;
      else if (req0 && cnt_q != LIM)
        cnt_d = cnt_q + 8'd1;
    end
  end

  // Loss counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Two-master arbiter for the boot flash / block RAM bus.
// Sequences decode, flash wait states and BRAM latency.
module ext_mem_arbiter
  import gb_mem_pkg::*;
#(
  parameter int          FLASH_WAIT   = 4,
  parameter logic [15:0] FLASH_TOP    = FLASH_TOP_DEFAULT,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  ext_mem_arbiter_if.slave   m0,
  ext_mem_arbiter_if.slave   m1,
  output logic [23:0]        flash_a,
  output logic               flash_adv_n,
  input  logic [7:0]         flash_d,
  output logic               bram_we,
  output logic [16:0]        bram_addr,
  output logic [7:0]         bram_din,
  input  logic [7:0]         bram_dout,
  output logic               busy
);

  localparam logic [3:0] WAIT_M1 = 4'(FLASH_WAIT - 1);

  state_e      state_q, state_d;
  logic        mst_q, mst_d;
  logic        we_q, we_d;
  logic        fl_q, fl_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [7:0]  rd0_q, rd0_d, rd1_q, rd1_d;
  logic        bwe_q, bwe_d;
  logic [16:0] baddr_q, baddr_d;
  logic [7:0]  bdin_q, bdin_d;
  logic [23:0] fa_q, fa_d;
  logic        adv_n_q, adv_n_d;
  logic        busy_q, busy_d;

  logic        win, valid;
  logic        s_we;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic        cap;
  logic [7:0]  cap_data;

  arb_prio_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clock  (clock),
    .reset_n(reset_n),
    .decide (state_q == S_IDLE),
    .req0   (m0.req),
    .req1   (m1.req),
    .winner (win),
    .valid  (valid)
  );

  assign s_we    = (win == MST_DMA) ? m1.we    : m0.we;
  assign s_addr  = (win == MST_DMA) ? m1.addr  : m0.addr;
  assign s_wdata = (win == MST_DMA) ? m1.wdata : m0.wdata;

  // Next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    mst_d    = mst_q;
    we_d     = we_q;
    fl_d     = fl_q;
    wcnt_d   = wcnt_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    bwe_d    = 1'b0;
    bdin_d   = '0;
    baddr_d  = baddr_q;
    fa_d     = fa_q;
    adv_n_d  = adv_n_q;
    cap      = 1'b0;
    cap_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          mst_d   = win;
          we_d    = s_we;
          fl_d    = (s_addr <= FLASH_TOP);
          fa_d    = {8'd0, s_addr};
          baddr_d = {1'b0, s_addr};
          gnt0_d  = (win == MST_CPU);
          gnt1_d  = (win == MST_DMA);
          if (s_we && s_addr > FLASH_TOP) begin
            bwe_d  = 1'b1;
            bdin_d = s_wdata;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else if (fl_q) begin
          adv_n_d = 1'b0;
          wcnt_d  = WAIT_M1;
          state_d = S_FWAIT;
        end else begin
          state_d = S_BCAP;
        end
      end
      S_FWAIT: begin
        if (wcnt_q == '0) begin
          cap      = 1'b1;
          cap_data = flash_d;
          adv_n_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_BCAP: begin
        cap      = 1'b1;
        cap_data = bram_dout;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cap) begin
      if (mst_q == MST_DMA) rd1_d = cap_data;
      else                  rd0_d = cap_data;
    end
    if (state_d == S_DONE && state_q != S_DONE) begin
      done0_d = (mst_q == MST_CPU);
      done1_d = (mst_q == MST_DMA);
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mst_q   <= MST_CPU;
      we_q    <= 1'b0;
      fl_q    <= 1'b0;
      wcnt_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      bwe_q   <= 1'b0;
      baddr_q <= '0;
      bdin_q  <= '0;
      fa_q    <= '0;
      adv_n_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mst_q   <= mst_d;
      we_q    <= we_d;
      fl_q    <= fl_d;
      wcnt_q  <= wcnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      bwe_q   <= bwe_d;
      baddr_q <= baddr_d;
      bdin_q  <= bdin_d;
      fa_q    <= fa_d;
      adv_n_q <= adv_n_d;
      busy_q  <= busy_d;
    end
  end

  assign m0.gnt      = gnt0_q;
  assign m0.done     = done0_q;
  assign m0.rdata    = rd0_q;
  assign m1.gnt      = gnt1_q;
  assign m1.done     = done1_q;
  assign m1.rdata    = rd1_q;
  assign flash_a     = fa_q;
  assign flash_adv_n = adv_n_q;
  assign bram_we     = bwe_q;
  assign bram_addr   = baddr_q;
  assign bram_din    = bdin_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Scoreboard bench for ext_mem_arbiter.
// Expected dones are queued at issue and popped on done.
module tb_ext_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic [23:0] flash_a;
  logic        flash_adv_n;
  logic [7:0]  flash_d;
  logic        bram_we;
  logic [16:0] bram_addr;
  logic [7:0]  bram_din;
  logic [7:0]  bram_dout;
  logic        busy;

  ext_mem_arbiter_if m0i ();
  ext_mem_arbiter_if m1i ();

  ext_mem_arbiter #(
    .FLASH_WAIT  (4),
    .FLASH_TOP   (16'h0140),
    .STARVE_LIMIT(3)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .m0         (m0i),
    .m1         (m1i),
    .flash_a    (flash_a),
    .flash_adv_n(flash_adv_n),
    .flash_d    (flash_d),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_dout  (bram_dout),
    .busy       (busy)
  );

  typedef struct {
    bit         m;
    int         cyc;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  int          nchk, nfail, cyc;
  int          nwe, nadv, nbusy, ng0, nd0, we_cyc;
  logic [16:0] we_addr;
  logic [23:0] adv_addr;
  logic [7:0]  mem [0:65535];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(posedge clock) cyc <= cyc + 1;

  // BRAM model, one-cycle synchronous read
  always @(posedge clock) begin
    bram_dout <= mem[bram_addr[15:0]];
    if (bram_we) mem[bram_addr[15:0]] = bram_din;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pop(input bit m);
    exp_t e;
    if (sb.size() == 0) begin
      chk("done_unexp", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      chk("done_mst", 32'(m), 32'(e.m));
      if (e.cyc >= 0) chk("done_cyc", cyc, e.cyc);
      if (e.rd) chk("rdata", m ? m1i.rdata : m0i.rdata, e.data);
    end
  endtask

  // Bus monitor: activity counters and done scoreboard
  always @(negedge clock) begin
    if (reset_n) begin
      if (bram_we) begin
        nwe++;
        we_cyc  = cyc;
        we_addr = bram_addr;
      end
      if (!flash_adv_n) begin
        nadv++;
        adv_addr = flash_a;
      end
      if (busy) nbusy++;
      if (m0i.gnt) ng0++;
      if (m0i.gnt || m1i.gnt)
        chk("gnt_excl", 32'(m0i.gnt & m1i.gnt), 0);
      if (m0i.done) begin
        nd0++;
        pop(1'b0);
      end
      if (m1i.done) pop(1'b1);
    end
  end

  function automatic logic gnt_of(input bit m);
    return m ? m1i.gnt : m0i.gnt;
  endfunction

  task automatic drive(input bit m, input logic r, input logic w,
                       input logic [15:0] a, input logic [7:0] d);
    if (m) begin
      m1i.req = r; m1i.we = w; m1i.addr = a; m1i.wdata = d;
    end else begin
      m0i.req = r; m0i.we = w; m0i.addr = a; m0i.wdata = d;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_txn(input bit m, input logic w,
                        input logic [15:0] a, input logic [7:0] d,
                        input int lat, input logic [7:0] rd,
                        output int t);
    int   n;
    exp_t e;
    wait_idle();
    nwe = 0; nadv = 0; nbusy = 0; ng0 = 0; nd0 = 0;
    t = cyc;
    e = '{m, t + lat, !w, rd};
    sb.push_back(e);
    drive(m, 1'b1, w, a, d);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!gnt_of(m) && n < 20);
    chk("gnt_cyc", cyc, t + 1);
    drive(m, 1'b0, 1'b0, 16'h0, 8'h0);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("sb_drain", 32'(sb.size()), 0);
    @(negedge clock);
  endtask

  initial begin
    int   t, n;
    exp_t e;
    bit   order [8];
    order = '{1, 1, 1, 0, 1, 1, 1, 0};
    nchk = 0; nfail = 0; cyc = 0;
    mem[16'h0141] = 8'h99;
    mem[16'hFF80] = 8'hA5;
    reset_n = 1'b0;
    flash_d = 8'h00;
    drive(0, 0, 0, 16'h0, 8'h0);
    drive(1, 0, 0, 16'h0, 8'h0);
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_adv_n", 32'(flash_adv_n), 1);
    chk("rst_gnt_done", {m0i.gnt, m0i.done, m1i.gnt, m1i.done}, 0);
    chk("rst_rdata", {m0i.rdata, m1i.rdata}, 0);
    chk("rst_bram", {bram_we, bram_addr, bram_din}, 0);
    chk("rst_flash_a", flash_a, 0);
    reset_n = 1'b1;

    do_txn(0, 1, 16'hC000, 8'h5A, 2, 8'h00, t);
    chk("wr_we_cnt", nwe, 1);
    chk("wr_we_cyc", we_cyc, t + 1);
    chk("wr_addr", we_addr, 17'h0C000);
    chk("wr_mem", mem[16'hC000], 8'h5A);

    do_txn(0, 0, 16'hC000, 8'h00, 3, 8'h5A, t);
    chk("brd_no_we", nwe, 0);

    flash_d = 8'h3C;
    do_txn(0, 0, 16'h0100, 8'h00, 6, 8'h3C, t);
    chk("frd_adv_cnt", nadv, 4);
    chk("frd_addr", adv_addr, 24'h000100);

    flash_d = 8'h77;
    do_txn(0, 0, 16'h0140, 8'h00, 6, 8'h77, t);
    chk("b140_adv_cnt", nadv, 4);
    chk("b140_addr", adv_addr, 24'h000140);

    do_txn(0, 0, 16'h0141, 8'h00, 3, 8'h99, t);
    chk("b141_adv_cnt", nadv, 0);

    do_txn(0, 1, 16'h0100, 8'hEE, 2, 8'h00, t);
    chk("fwr_no_we", nwe, 0);
    chk("fwr_no_adv", nadv, 0);
    chk("fwr_rdata_keep", m0i.rdata, 8'h99);

    do_txn(1, 0, 16'hFF80, 8'h00, 3, 8'hA5, t);
    chk("m1rd_m0_gnt", ng0, 0);
    chk("m1rd_m0_done", nd0, 0);
    chk("m1rd_m0_rdata", m0i.rdata, 8'h99);
    chk("m1rd_busy_cyc", nbusy, 3);

    do_txn(1, 1, 16'hFFFF, 8'h42, 2, 8'h00, t);
    chk("ffff_addr", we_addr, 17'h0FFFF);
    chk("m1wr_rdata_keep", m1i.rdata, 8'hA5);

    wait_idle();
    foreach (order[i]) begin
      e = '{order[i], -1, 1'b0, 8'h00};
      sb.push_back(e);
    end
    drive(0, 1, 1, 16'hD000, 8'h11);
    drive(1, 1, 1, 16'hD001, 8'h22);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    drive(0, 0, 0, 16'h0, 8'h0);
    drive(1, 0, 0, 16'h0, 8'h0);
    chk("starve_drain", 32'(sb.size()), 0);
    repeat (2) @(negedge clock);
    chk("starve_idle", 32'(busy), 0);

    wait_idle();
    flash_d = 8'h3C;
    drive(0, 1, 0, 16'h0100, 8'h00);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m0i.gnt && n < 20);
    drive(0, 0, 0, 16'h0, 8'h0);
    n = 0;
    while (flash_adv_n && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    chk("fw_adv_low", 32'(flash_adv_n), 0);
    reset_n = 1'b0;
    #1;
    chk("arst_adv_n", 32'(flash_adv_n), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", {m0i.done, m1i.done}, 0);
    chk("arst_rdata", m0i.rdata, 8'h00);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_idle", 32'(busy), 0);

    do_txn(1, 0, 16'hC000, 8'h00, 3, 8'h5A, t);
    chk("post_rst_m0_rdata", m0i.rdata, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
